// File: rtl/lzc_arbiter_pkg.sv
// Shared types and defaults for the leading-zero-counter arbiter.
// The counter result is ZW bits wide, enough for 0..WORD*WIDTH with the default sizes.
package lzc_arbiter_pkg;

   localparam int WIDTH_DEF = 8;
   localparam int WORD_DEF  = 4;
   localparam int NREQ_DEF  = 4;
   localparam int ZW        = 6;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_FEED = 3'd1,
      ST_WAIT = 3'd2,
      ST_RESP = 3'd3,
      ST_GAP  = 3'd4
   } state_t;

endpackage

// File: rtl/lzc_arbiter_rr_pick.sv
// Combinational round-robin selector.
// The search starts one past ptr and wraps, so the last winner has the lowest priority.
module lzc_rr_pick #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [IDW-1:0]  id,
   output logic            any
);

   logic found;
   int   cand;

   always_comb begin
      id    = '0;
      any   = |req;
      found = 1'b0;
      cand  = 0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = (int'(ptr) + k) % NREQ;
         if (!found && req[cand]) begin
            found = 1'b1;
            id    = IDW'(cand);
         end
      end
   end

endmodule

// File: rtl/lzc_arbiter.sv
// Shares one byte-serial leading-zero counter among NREQ requesters.
// Words are fed MSB byte first; the count comes back tagged with the requester ID.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | waiting for any request; picks the winner and latches it
//   ST_FEED | streaming bytes to the counter, stops early on a result
//   ST_WAIT | all bytes sent, waiting for the result or the timeout
//   ST_RESP | response strobe is on the outputs this cycle
//   ST_GAP  | forced idle cycles before the next arbitration
module lzc_arbiter
   import lzc_arbiter_pkg::*;
#(
   parameter int WIDTH   = WIDTH_DEF,
   parameter int WORD    = WORD_DEF,
   parameter int NREQ    = NREQ_DEF,
   parameter int IDW     = 2,
   parameter int TIMEOUT = 16,
   parameter int GAP     = 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NREQ-1:0]             req,
   input  logic [NREQ*WORD*WIDTH-1:0]  req_data,
   input  logic [NREQ-1:0]             req_mode,
   output logic [NREQ-1:0]             gnt,
   output logic                        rsp_valid,
   output logic [IDW-1:0]              rsp_id,
   output logic [ZW-1:0]               rsp_zeros,
   output logic                        rsp_err,
   output logic                        lzc_ivalid,
   output logic [WIDTH-1:0]            lzc_data,
   output logic                        lzc_mode,
   input  logic [ZW-1:0]               lzc_zeros,
   input  logic                        lzc_ovalid
);

   localparam int WW     = WORD * WIDTH;
   localparam int IXW    = $clog2(WORD + 1);
   localparam int TW     = $clog2(TIMEOUT + 1);
   localparam int GW     = (GAP > 1) ? $clog2(GAP) : 1;
   localparam int GAP_LD = (GAP > 0) ? GAP - 1 : 0;
   localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

   state_t          state, state_nxt;
   logic [IDW-1:0]  ptr;
   logic [IDW-1:0]  pick_id;
   logic            pick_any;
   logic [WW-1:0]   sel_word;
   logic            sel_mode;
   logic [WW-1:0]   word_q;
   logic [IDW-1:0]  id_q;
   logic [IXW-1:0]  idx;
   logic [TW-1:0]   tmr;
   logic [GW-1:0]   gap_cnt;

   lzc_rr_pick #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_pick (
      .req  (req),
      .ptr  (ptr),
      .id   (pick_id),
      .any  (pick_any)
   );

   always_comb begin
      sel_word = '0;
      sel_mode = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         if (pick_id == IDW'(k)) begin
            sel_word = req_data[k*WW +: WW];
            sel_mode = req_mode[k];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (pick_any) state_nxt = ST_FEED;
         ST_FEED: begin
            if (lzc_ovalid)             state_nxt = ST_RESP;
            else if (idx == IXW'(WORD)) state_nxt = ST_WAIT;
         end
         ST_WAIT: if (lzc_ovalid || tmr == '0) state_nxt = ST_RESP;
         ST_RESP: state_nxt = (GAP == 0) ? ST_IDLE : ST_GAP;
         ST_GAP:  if (gap_cnt == '0) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr        <= IDW'(NREQ - 1);
         gnt        <= '0;
         rsp_valid  <= 1'b0;
         rsp_id     <= '0;
         rsp_zeros  <= '0;
         rsp_err    <= 1'b0;
         lzc_ivalid <= 1'b0;
         lzc_data   <= '0;
         lzc_mode   <= 1'b0;
         word_q     <= '0;
         id_q       <= '0;
         idx        <= '0;
         tmr        <= '0;
         gap_cnt    <= '0;
      end else begin
         gnt       <= '0;
         rsp_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (pick_any) begin
                  ptr        <= pick_id;
                  id_q       <= pick_id;
                  gnt        <= ONE_HOT0 << pick_id;
                  lzc_mode   <= sel_mode;
                  lzc_ivalid <= 1'b1;
                  lzc_data   <= sel_word[WW-1 -: WIDTH];
                  word_q     <= sel_word << WIDTH;
                  idx        <= IXW'(1);
               end
            end
            ST_FEED: begin
               // An early result (stop-at-nonzero mode) cuts the stream short.
               if (lzc_ovalid) begin
                  lzc_ivalid <= 1'b0;
                  rsp_valid  <= 1'b1;
                  rsp_id     <= id_q;
                  rsp_zeros  <= lzc_zeros;
                  rsp_err    <= 1'b0;
               end else if (idx == IXW'(WORD)) begin
                  lzc_ivalid <= 1'b0;
                  tmr        <= TW'(TIMEOUT);
               end else begin
                  lzc_data <= word_q[WW-1 -: WIDTH];
                  word_q   <= word_q << WIDTH;
                  idx      <= idx + IXW'(1);
               end
            end
            ST_WAIT: begin
               if (lzc_ovalid) begin
                  rsp_valid <= 1'b1;
                  rsp_id    <= id_q;
                  rsp_zeros <= lzc_zeros;
                  rsp_err   <= 1'b0;
               end else if (tmr == '0) begin
                  rsp_valid <= 1'b1;
                  rsp_id    <= id_q;
                  rsp_zeros <= '0;
                  rsp_err   <= 1'b1;
               end else begin
                  tmr <= tmr - TW'(1);
               end
            end
            ST_RESP: gap_cnt <= GW'(GAP_LD);
            ST_GAP:  if (gap_cnt != '0) gap_cnt <= gap_cnt - GW'(1);
            default: ;
         endcase
      end
   end

endmodule
